ifu_fetch: RTL and testbench

//   Instruction fetch unit; consumes the PC stream produced by the PC update logic.

---
 rtl/ifu_fetch.sv | 151 +++++++++++++++
 tb/tb_ifu_fetch.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit.
//   Takes one PC per transaction, issues a single-beat read on an AR/R channel, and
//   returns the fetched word with its PC to decode over valid/ready. A flush discards
//   the fetch in progress. A response that is still outstanding when the flush arrives
//   is absorbed in StDrop, so it never reaches decode.
// Optional feature: define IFU_MISALIGN_CHECK_EN to trap PCs with pc[1:0] != 0 without
//   issuing a read (exc = 2). When it is undefined, pc[1:0] is ignored.
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_pc, i_pc_valid, o_pc_ready      PC stream in
//   i_flush                           redirect pulse
//   o_araddr, o_arvalid, i_arready    read address channel
//   i_rdata, i_rresp, i_rvalid,
//   o_rready                          read data channel
//   o_inst, o_inst_pc, o_inst_exc,
//   o_inst_valid, i_inst_ready        instruction out to decode
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module ifu_fetch #(
  parameter int unsigned       ADDR_W   = `CPU_WIDTH,
  parameter int unsigned       INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_pc_valid,
  output logic              o_pc_ready,
  input  logic              i_flush,
  output logic [ADDR_W-1:0] o_araddr,
  output logic              o_arvalid,
  input  logic              i_arready,
  input  logic [INST_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  input  logic              i_rvalid,
  output logic              o_rready,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  output logic [1:0]        o_inst_exc,
  output logic              o_inst_valid,
  input  logic              i_inst_ready
);

  typedef enum logic [2:0] {StIdle, StAr, StR, StDrop, StOut} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                drop_q;
  logic [INST_W-1:0]   inst_q;
  logic [ADDR_W-1:0]   inst_pc_q;
  logic [1:0]          exc_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                inst_valid_q;

  logic accept;
  logic misalign;

  // A flush in StOut blocks the back-to-back accept for that cycle.
  assign o_pc_ready = (state_q == StIdle) |
                      ((state_q == StOut) & i_inst_ready & ~i_flush);
  assign accept     = i_pc_valid & o_pc_ready;

`ifdef IFU_MISALIGN_CHECK_EN
  assign misalign = (i_pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      drop_q       <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      exc_q        <= 2'd0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_valid_q <= 1'b0;
    end else if (accept) begin
      // Reached from StIdle or from a completed handshake in StOut.
      pc_q   <= i_pc;
      drop_q <= 1'b0;
      if (misalign) begin
        state_q      <= StOut;
        inst_q       <= NOP_INST;
        inst_pc_q    <= i_pc;
        exc_q        <= 2'd2;
        inst_valid_q <= 1'b1;
      end else begin
        state_q      <= StAr;
        arvalid_q    <= 1'b1;
        inst_valid_q <= 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StAr: begin
          // The address must stay valid once presented; the flush is only remembered.
          if (i_flush) drop_q <= 1'b1;
          if (i_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= (drop_q | i_flush) ? StDrop : StR;
          end
        end
        StR: begin
          if (i_rvalid) begin
            rready_q <= 1'b0;
            if (i_flush) begin
              state_q <= StIdle;
            end else begin
              inst_q       <= (i_rresp != 2'b00) ? NOP_INST : i_rdata;
              exc_q        <= (i_rresp != 2'b00) ? 2'd1 : 2'd0;
              inst_pc_q    <= pc_q;
              inst_valid_q <= 1'b1;
              state_q      <= StOut;
            end
          end else if (i_flush) begin
            state_q <= StDrop;
          end
        end
        StDrop: begin
          if (i_rvalid) begin
            rready_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StOut: begin
          if (i_flush || i_inst_ready) begin
            inst_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_araddr     = pc_q;
  assign o_arvalid    = arvalid_q;
  assign o_rready     = rready_q;
  assign o_inst       = inst_q;
  assign o_inst_pc    = inst_pc_q;
  assign o_inst_exc   = exc_q;
  assign o_inst_valid = inst_valid_q;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  localparam logic [31:0] Nop = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic        flush = 1'b0;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [1:0]  inst_exc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pc         (pc),
    .i_pc_valid   (pc_valid),
    .o_pc_ready   (pc_ready),
    .i_flush      (flush),
    .o_araddr     (araddr),
    .o_arvalid    (arvalid),
    .i_arready    (arready),
    .i_rdata      (rdata),
    .i_rresp      (rresp),
    .i_rvalid     (rvalid),
    .o_rready     (rready),
    .o_inst       (inst),
    .o_inst_pc    (inst_pc),
    .o_inst_exc   (inst_exc),
    .o_inst_valid (inst_valid),
    .i_inst_ready (inst_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory image and fault map used by the random phase.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h12345678;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    if (a[5:2] == 4'hF) return 2'b10;
    if (a[5:2] == 4'h7) return 2'b11;
    return 2'b00;
  endfunction

  // Wait (bounded) for an instruction, check it, then complete the handshake.
  task automatic finish_out(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                            input logic [1:0] ee);
    for (int i = 0; i < 10 && !inst_valid; i++) begin
      @(negedge clk);
      #1;
    end
    chk({tag, "_valid"}, inst_valid, 1);
    chk({tag, "_inst"}, inst, ei);
    chk({tag, "_pc"}, inst_pc, ep);
    chk({tag, "_exc"}, inst_exc, ee);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    #1;
    chk({tag, "_drained"}, inst_valid, 0);
  endtask

  // Random-phase model state: PCs accepted and not yet delivered or flushed, and
  // addresses the memory has accepted but not yet answered.
  logic [31:0] exp_q[$];
  logic [31:0] mem_q[$];
  bit          rv_on = 0;
  bit          held_ar = 0;
  logic [31:0] held_addr;
  bit          held_inst = 0;
  logic [31:0] h_inst, h_pc;
  logic [1:0]  h_exc;

  task automatic rand_cycle(input bit drain);
    logic [31:0] a, ei, ep;
    logic [1:0]  ee;
    bit          mis;
    bit          acc, ar_hs, r_hs, d_hs;
    @(negedge clk);
    flush    = drain ? 1'b0 : ($urandom_range(0, 19) == 0);
    pc_valid = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
    a = 32'h80000000 | ($urandom & 32'h000FFFFC);
    if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
    pc         = a;
    inst_ready = flush ? 1'b0 : (drain ? 1'b1 : ($urandom_range(0, 3) != 0));
    arready    = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
    if (mem_q.size() != 0 && !rv_on) rv_on = drain ? 1'b1 : 1'($urandom_range(0, 1));
    rvalid = rv_on;
    if (rv_on) begin
      rdata = mem_word(mem_q[0]);
      rresp = mem_resp(mem_q[0]);
    end else begin
      rdata = $urandom;
      rresp = 2'($urandom);
    end
    #1;
    acc   = pc_valid & pc_ready;
    ar_hs = arvalid & arready;
    r_hs  = rvalid & rready;
    d_hs  = inst_valid & inst_ready;
    chk("ar_r_exclusive", arvalid & rready, 0);
    if (held_ar) begin
      chk("ar_held_valid", arvalid, 1);
      chk("ar_held_addr", araddr, held_addr);
    end
    if (held_inst) begin
      chk("out_held_valid", inst_valid, 1);
      chk("out_held_inst", inst, h_inst);
      chk("out_held_pc", inst_pc, h_pc);
      chk("out_held_exc", inst_exc, h_exc);
    end
    if (d_hs) begin
      chk("delivery_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        ep  = exp_q.pop_front();
        mis = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
        mis = (ep[1:0] != 2'b00);
`endif
        if (mis) begin
          ei = Nop;
          ee = 2'd2;
        end else if (mem_resp(ep) != 2'b00) begin
          ei = Nop;
          ee = 2'd1;
        end else begin
          ei = mem_word(ep);
          ee = 2'd0;
        end
        chk("rand_inst", inst, ei);
        chk("rand_pc", inst_pc, ep);
        chk("rand_exc", inst_exc, ee);
      end
    end
    if (flush) exp_q.delete();
    if (acc) exp_q.push_back(pc);
    if (ar_hs) begin
      chk("one_outstanding", mem_q.size(), 0);
      mem_q.push_back(araddr);
    end
    if (r_hs) begin
      void'(mem_q.pop_front());
      rv_on = 1'b0;
    end
    held_ar   = arvalid & ~arready;
    held_addr = araddr;
    held_inst = inst_valid & ~inst_ready & ~flush;
    h_inst    = inst;
    h_pc      = inst_pc;
    h_exc     = inst_exc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc_ready", pc_ready, 1);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_exc", inst_exc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: zero-wait fetch, latency 3
    @(negedge clk);
    pc = 32'h80000000; pc_valid = 1; arready = 1; rvalid = 1; rdata = 32'h00500093;
    #1;
    chk("t1_accept", pc_ready, 1);
    @(negedge clk);
    pc_valid = 0;
    #1;
    chk("t1_arvalid", arvalid, 1);
    chk("t1_araddr", araddr, 32'h80000000);
    @(negedge clk);
    #1;
    chk("t1_rready", rready, 1);
    chk("t1_no_early_valid", inst_valid, 0);
    @(negedge clk);
    #1;
    chk("t1_valid_at_3", inst_valid, 1);
    chk("t1_pc_ready_stall", pc_ready, 0);
    finish_out("t1", 32'h00500093, 32'h80000000, 2'd0);

    // T2: address stall keeps AR stable and blocks new PCs
    @(negedge clk);
    rvalid = 0; arready = 0; pc = 32'h80000004; pc_valid = 1;
    @(negedge clk);
    pc = 32'h80000F00;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_arvalid", arvalid, 1);
      chk("t2_araddr", araddr, 32'h80000004);
      chk("t2_pc_ready", pc_ready, 0);
      @(negedge clk);
    end
    pc_valid = 0; arready = 1; rvalid = 1; rdata = 32'h00100113;
    finish_out("t2", 32'h00100113, 32'h80000004, 2'd0);

    // T3: flush in R; the late beat is dropped
    @(negedge clk);
    rvalid = 0; pc = 32'h80000008; pc_valid = 1;
    @(negedge clk);
    pc_valid = 0;
    @(negedge clk);
    #1;
    chk("t3_in_r", rready, 1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    #1;
    chk("t3_drop_rready", rready, 1);
    chk("t3_drop_novalid", inst_valid, 0);
    @(negedge clk);
    rvalid = 1; rdata = 32'hDEADBEEF;
    @(negedge clk);
    rvalid = 0;
    #1;
    chk("t3_idle", pc_ready, 1);
    chk("t3_no_deadbeef", inst_valid, 0);
    pc = 32'h80000100; pc_valid = 1; rvalid = 1; rdata = 32'h11111111;
    @(negedge clk);
    pc_valid = 0;
    finish_out("t3", 32'h11111111, 32'h80000100, 2'd0);

    // T4: access fault
    @(negedge clk);
    pc = 32'h8000000C; pc_valid = 1; rresp = 2'b10; rdata = 32'hAAAA5555;
    @(negedge clk);
    pc_valid = 0;
    finish_out("t4", Nop, 32'h8000000C, 2'd1);
    rresp = 2'b00;

    // T5: decode stall then back-to-back accept
    @(negedge clk);
    pc = 32'h80000010; pc_valid = 1; rdata = 32'h00208033;
    @(negedge clk);
    pc_valid = 0;
    for (int i = 0; i < 10 && !inst_valid; i++) begin
      @(negedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_hold_valid", inst_valid, 1);
      chk("t5_hold_inst", inst, 32'h00208033);
      chk("t5_hold_pc", inst_pc, 32'h80000010);
      @(negedge clk);
    end
    inst_ready = 1; pc_valid = 1; pc = 32'h80000200; rdata = 32'h00C58593;
    #1;
    chk("t5_b2b_ready", pc_ready, 1);
    @(negedge clk);
    inst_ready = 0; pc_valid = 0;
    #1;
    chk("t5_b2b_arvalid", arvalid, 1);
    chk("t5_b2b_araddr", araddr, 32'h80000200);
    finish_out("t5", 32'h00C58593, 32'h80000200, 2'd0);

    // T6: misaligned PC
    @(negedge clk);
    pc = 32'h80000002; pc_valid = 1; rdata = 32'h00000517;
    @(negedge clk);
    pc_valid = 0;
    #1;
`ifdef IFU_MISALIGN_CHECK_EN
    chk("t6_no_ar", arvalid, 0);
    finish_out("t6", Nop, 32'h80000002, 2'd2);
`else
    chk("t6_arvalid", arvalid, 1);
    chk("t6_araddr", araddr, 32'h80000002);
    finish_out("t6", 32'h00000517, 32'h80000002, 2'd0);
`endif

    // Async reset mid-transaction
    @(negedge clk);
    rvalid = 0; arready = 0; pc = 32'h80000020; pc_valid = 1;
    @(negedge clk);
    pc_valid = 0;
    #1;
    chk("rst_mid_ar", arvalid, 1);
    rst_n = 0;
    #1;
    chk("rst_mid_arvalid", arvalid, 0);
    chk("rst_mid_pc_ready", pc_ready, 1);
    @(negedge clk);
    rst_n = 1;

    // Random traffic against the transaction-level model
    for (int i = 0; i < 3000; i++) rand_cycle(1'b0);
    for (int i = 0; i < 200 && (i < 20 || exp_q.size() != 0 || mem_q.size() != 0); i++)
      rand_cycle(1'b1);
    chk("drain_empty", exp_q.size() + mem_q.size(), 0);
    chk("drain_idle", pc_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
